rv_ctl: RTL and testbench
=========================

Name: rv_ctl

Overview:
- Multicycle control FSM for the RV32I-subset core.
- Consumes the instruction register contents and the ALU zero flag from the datapath.
- Drives every datapath enable and mux select, plus data-memory write and wait handshaking.
- Sits directly upstream of the datapath; it is the only source of datapath control.

Parameters:
- XLEN, 32, instruction and datapath width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- instr  in  XLEN  instruction register contents
- zero  in  1  ALU result == 0
- dmem_ready  in  1  data memory transfer complete (see Optional Feature)
- pcsourse  out  1  PC source: 0 = PC_PLUS4, 1 = PC_ALU
- pcwrite  out  1  PC load enable
- pccen  out  1  PCC (current PC) capture enable
- irwrite  out  1  IR load enable
- wbsel  out  2  writeback: 0 = MDR, 1 = ALUOUT, 2 = PC
- regwen  out  1  register file write enable
- immsel  out  3  immediate: 0 = J, 1 = B, 2 = S, 3 = L(I-type)
- asel  out  2  ALU A: 0 = REG, 1 = PCC
- bsel  out  1  ALU B: 0 = REG, 1 = IMM
- alusel  out  4  ALU op: {funct7[5], funct3} encoding (ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111)
- mdrwrite  out  1  MDR load enable
- dmem_wen  out  1  data memory write strobe
- retire  out  1  one-cycle pulse on the last cycle of each instruction
- halted  out  1  illegal instruction seen; core stopped
- state_o  out  4  current state, debug

Behaviour:
- State register updates on posedge clk; cleared asynchronously by rst.
- All outputs are combinational from the state and instr; default is 0 for every output not listed in a state.
- While rst is high: state = FETCH, and all enables (pcwrite, pccen, irwrite, regwen, mdrwrite, dmem_wen, retire) are forced to 0; halted = 0.
- First active cycle after reset release is FETCH. An rst pulse mid-instruction aborts it with no partial register write.
- FETCH: irwrite = 1, pccen = 1, pcwrite = 1, pcsourse = PC_PLUS4. Next state is DECODE.
- DECODE: asel = PCC, bsel = IMM, alusel = ADD; immsel = B for branch, J for JAL, else L. ALUOUT then holds the branch/jump target. Dispatch on opcode:
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 0000011 (funct3 = 010) → ADDR_L
  - 0100011 (funct3 = 010) → ADDR_S
  - 1100011 (funct3 000/001) → BRANCH
  - 1101111 → JAL
  - anything else → HALT
- EXEC_R: asel = REG, bsel = REG, alusel = {instr[30], funct3}. Next state is WB_ALU.
- EXEC_I: asel = REG, bsel = IMM, immsel = L. alusel = {instr[30], funct3} when funct3 = 101, else {0, funct3}. Next state is WB_ALU.
- WB_ALU: wbsel = ALUOUT, regwen = 1, retire = 1; ALU controls repeat the EXEC values. Next state is FETCH.
- ADDR_L / ADDR_S: asel = REG, bsel = IMM, ADD; immsel = L or S respectively. Next state is MEM_RD or MEM_WR.
- MEM_RD: mdrwrite = 1; address controls held identical to ADDR so ALUOUT stays stable. Next state is WB_MEM.
- WB_MEM: wbsel = MDR, regwen = 1, retire = 1. Next state is FETCH.
- MEM_WR: dmem_wen = 1, retire = 1, address controls held. Next state is FETCH.
- BRANCH: asel = REG, bsel = REG, alusel = SUB.
  - taken = zero XOR funct3[0].
  - If taken: pcwrite = 1, pcsourse = PC_ALU.
  - retire = 1. Next state is FETCH.
- JAL: wbsel = PC, regwen = 1 (PC already equals PCC + 4), pcwrite = 1, pcsourse = PC_ALU, retire = 1. Next state is FETCH.
- HALT: halted = 1, all enables 0. Stays in HALT until rst.
- Latency in cycles: R/I = 4, load = 5, store = 4, branch = 3, JAL = 3, plus wait cycles.
- rd = x0 needs no special handling here; the datapath masks the write.

Optional Feature:
- Macro: RV_CTL_MEMWAIT_EN.
- Enabled: MEM_RD and MEM_WR hold, with outputs unchanged, until dmem_ready = 1.
  - mdrwrite / dmem_wen stay asserted each wait cycle.
  - retire (MEM_WR) is asserted only in the ready cycle.
- Disabled: dmem_ready is ignored and MEM states last exactly 1 cycle.

Decomposition:
- Package rv_ctl_pkg holds:
  - state enum (FETCH, DECODE, EXEC_R, EXEC_I, WB_ALU, ADDR_L, ADDR_S, MEM_RD, MEM_WR, WB_MEM, BRANCH, JAL, HALT)
  - opcode constants
  - PC/WB/IMM/ALUA/ALUB/ALU select constants, with values identical to the datapath's.
- Sub-module rv_alu_dec: combinational {opcode, funct3, instr[30]} → alusel.

Test Plan:
- add x3,x1,x2 (0x002081B3) after reset → states FETCH, DECODE, EXEC_R, WB_ALU; alusel = 0000 in EXEC; regwen = 1, wbsel = 1 in cycle 4; retire once.
- sub x3,x1,x2 (0x402081B3) → alusel = 1000 in EXEC_R. srai x5,x5,2 (0x4022D293) → alusel = 1101 with bsel = 1.
- lw x4,8(x1) (0x0080A203) with macro on, dmem_ready low 2 cycles → MEM_RD lasts 3 cycles with mdrwrite = 1 throughout; then WB_MEM with wbsel = 0; 7 cycles total.
- beq x1,x2,+16 (0x00208863): zero = 1 → pcwrite = 1, pcsourse = 1 in BRANCH; zero = 0 → pcwrite = 0. bne (0x00209863) gives the inverse.
- jal x1,+8 (0x008000EF) → DECODE immsel = 0; JAL state has regwen = 1, wbsel = 2, pcwrite = 1, pcsourse = 1.
- Opcode 0x0000007F → HALT; halted = 1 and no enables for 10 cycles. rst asserted during EXEC_R → outputs 0 immediately; FETCH after release.

Source files
------------

// File: rtl/rv_ctl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : rv_ctl_pkg                                                 |
// | Shared state encoding, opcodes and datapath select codes for the     |
// | multicycle RV32I-subset control FSM.                                 |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package rv_ctl_pkg;

  // Controller states; the numeric values are visible on state_o
  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    EXEC_R = 4'd2,
    EXEC_I = 4'd3,
    WB_ALU = 4'd4,
    ADDR_L = 4'd5,
    ADDR_S = 4'd6,
    MEM_RD = 4'd7,
    MEM_WR = 4'd8,
    WB_MEM = 4'd9,
    BRANCH = 4'd10,
    JAL    = 4'd11,
    HALT   = 4'd12
  } state_t;

  // Major opcodes
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // Word-sized load/store is the only width supported
  localparam logic [2:0] F3_WORD = 3'b010;

  // PC source
  localparam logic PC_PLUS4 = 1'b0;
  localparam logic PC_ALU   = 1'b1;

  // Writeback source
  localparam logic [1:0] WB_MDR    = 2'd0;
  localparam logic [1:0] WB_ALUOUT = 2'd1;
  localparam logic [1:0] WB_PC     = 2'd2;

  // Immediate format
  localparam logic [2:0] IMM_J = 3'd0;
  localparam logic [2:0] IMM_B = 3'd1;
  localparam logic [2:0] IMM_S = 3'd2;
  localparam logic [2:0] IMM_L = 3'd3;

  // ALU operand selects
  localparam logic [1:0] ALUA_REG = 2'd0;
  localparam logic [1:0] ALUA_PCC = 2'd1;
  localparam logic       ALUB_REG = 1'b0;
  localparam logic       ALUB_IMM = 1'b1;

  // ALU operations, {funct7[5], funct3}
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

endpackage
`default_nettype wire

// File: rtl/rv_alu_dec.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : rv_alu_dec                                                 |
// | Maps {opcode, funct3, instr[30]} to the ALU operation used while an  |
// | R- or I-type instruction executes; ADD for everything else.          |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module rv_alu_dec
  import rv_ctl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] alusel
);

  // For OP-IMM, instr[30] is immediate data except on shifts-right (SRLI/SRAI)
  always_comb begin
    alusel = ALU_ADD;
    case (opcode)
      OPC_OP:     alusel = {funct7_5, funct3};
      OPC_OP_IMM: alusel = (funct3 == 3'b101) ? {funct7_5, funct3} : {1'b0, funct3};
      default:    alusel = ALU_ADD;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/rv_ctl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : rv_ctl                                                     |
// | Multicycle control FSM for the RV32I-subset core. Drives every       |
// | datapath enable and select from the current state and the IR.       |
// | Build option: RV_CTL_MEMWAIT_EN - memory states wait for dmem_ready. |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module rv_ctl
  import rv_ctl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] instr,
  input  logic            zero,
  input  logic            dmem_ready,
  output logic            pcsourse,
  output logic            pcwrite,
  output logic            pccen,
  output logic            irwrite,
  output logic [1:0]      wbsel,
  output logic            regwen,
  output logic [2:0]      immsel,
  output logic [1:0]      asel,
  output logic            bsel,
  output logic [3:0]      alusel,
  output logic            mdrwrite,
  output logic            dmem_wen,
  output logic            retire,
  output logic            halted,
  output logic [3:0]      state_o
);

  state_t     state_q, state_d;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [3:0] alu_exec;
  logic       taken;
  logic       mem_done;
  logic       unused_instr;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  // BEQ (funct3=000) takes on zero, BNE (funct3=001) on non-zero
  assign taken  = zero ^ funct3[0];
  // Register indices and most immediate bits belong to the datapath only
  assign unused_instr = ^{instr[XLEN-1:31], instr[29:15], instr[11:7]};

`ifdef RV_CTL_MEMWAIT_EN
  assign mem_done = dmem_ready;
`else
  logic unused_dmem_ready;
  assign unused_dmem_ready = dmem_ready;
  assign mem_done          = 1'b1;
`endif

  rv_alu_dec u_alu_dec (
    .opcode   (opcode),
    .funct3   (funct3),
    .funct7_5 (instr[30]),
    .alusel   (alu_exec)
  );

  // Next-state selection, including opcode dispatch and illegal-instruction trap
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (opcode)
          OPC_OP:     state_d = EXEC_R;
          OPC_OP_IMM: state_d = EXEC_I;
          OPC_LOAD:   state_d = (funct3 == F3_WORD) ? ADDR_L : HALT;
          OPC_STORE:  state_d = (funct3 == F3_WORD) ? ADDR_S : HALT;
          OPC_BRANCH: state_d = (funct3[2:1] == 2'b00) ? BRANCH : HALT;
          OPC_JAL:    state_d = JAL;
          default:    state_d = HALT;
        endcase
      end
      EXEC_R: state_d = WB_ALU;
      EXEC_I: state_d = WB_ALU;
      WB_ALU: state_d = FETCH;
      ADDR_L: state_d = MEM_RD;
      ADDR_S: state_d = MEM_WR;
      MEM_RD: state_d = mem_done ? WB_MEM : MEM_RD;
      WB_MEM: state_d = FETCH;
      MEM_WR: state_d = mem_done ? FETCH : MEM_WR;
      BRANCH: state_d = FETCH;
      JAL:    state_d = FETCH;
      HALT:   state_d = HALT;
      default: state_d = HALT;
    endcase
  end

  // State register, asynchronously returned to FETCH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  // Datapath controls per state; reset squashes every enable so an aborted
  // instruction leaves no partial architectural update
  always_comb begin
    pcsourse = PC_PLUS4;
    pcwrite  = 1'b0;
    pccen    = 1'b0;
    irwrite  = 1'b0;
    wbsel    = WB_MDR;
    regwen   = 1'b0;
    immsel   = IMM_J;
    asel     = ALUA_REG;
    bsel     = ALUB_REG;
    alusel   = ALU_ADD;
    mdrwrite = 1'b0;
    dmem_wen = 1'b0;
    retire   = 1'b0;
    halted   = 1'b0;
    case (state_q)
      FETCH: begin
        irwrite = 1'b1;
        pccen   = 1'b1;
        pcwrite = 1'b1;
      end
      DECODE: begin
        // Precompute PCC + imm so ALUOUT holds the branch/jump target
        asel   = ALUA_PCC;
        bsel   = ALUB_IMM;
        alusel = ALU_ADD;
        if (opcode == OPC_BRANCH)   immsel = IMM_B;
        else if (opcode == OPC_JAL) immsel = IMM_J;
        else                        immsel = IMM_L;
      end
      EXEC_R: begin
        alusel = alu_exec;
      end
      EXEC_I: begin
        bsel   = ALUB_IMM;
        immsel = IMM_L;
        alusel = alu_exec;
      end
      WB_ALU: begin
        // Keep the ALU inputs steady through the writeback cycle
        if (opcode == OPC_OP_IMM) begin
          bsel   = ALUB_IMM;
          immsel = IMM_L;
        end
        alusel = alu_exec;
        wbsel  = WB_ALUOUT;
        regwen = 1'b1;
        retire = 1'b1;
      end
      ADDR_L: begin
        bsel   = ALUB_IMM;
        immsel = IMM_L;
      end
      MEM_RD: begin
        bsel     = ALUB_IMM;
        immsel   = IMM_L;
        mdrwrite = 1'b1;
      end
      WB_MEM: begin
        wbsel  = WB_MDR;
        regwen = 1'b1;
        retire = 1'b1;
      end
      ADDR_S: begin
        bsel   = ALUB_IMM;
        immsel = IMM_S;
      end
      MEM_WR: begin
        bsel     = ALUB_IMM;
        immsel   = IMM_S;
        dmem_wen = 1'b1;
        retire   = mem_done;
      end
      BRANCH: begin
        alusel = ALU_SUB;
        retire = 1'b1;
        if (taken) begin
          pcwrite  = 1'b1;
          pcsourse = PC_ALU;
        end
      end
      JAL: begin
        // PC already advanced to PCC + 4 in FETCH, which is the link value
        wbsel    = WB_PC;
        regwen   = 1'b1;
        pcwrite  = 1'b1;
        pcsourse = PC_ALU;
        retire   = 1'b1;
      end
      HALT: begin
        halted = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      pcwrite  = 1'b0;
      pccen    = 1'b0;
      irwrite  = 1'b0;
      regwen   = 1'b0;
      mdrwrite = 1'b0;
      dmem_wen = 1'b0;
      retire   = 1'b0;
      halted   = 1'b0;
    end
  end

  assign state_o = state_q;

endmodule
`default_nettype wire

// File: tb/tb_rv_ctl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_rv_ctl                                                  |
// | Self-checking bench for rv_ctl: directed table, corner sequences and |
// | random instruction streams against an instruction-level model.       |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_rv_ctl;
  import rv_ctl_pkg::*;

`ifdef RV_CTL_MEMWAIT_EN
  localparam bit MEMWAIT = 1'b1;
`else
  localparam bit MEMWAIT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        zero;
  logic        dmem_ready;
  logic        pcsourse, pcwrite, pccen, irwrite, regwen, bsel;
  logic        mdrwrite, dmem_wen, retire, halted;
  logic [1:0]  wbsel, asel;
  logic [2:0]  immsel;
  logic [3:0]  alusel, state_o;

  rv_ctl #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .instr(instr), .zero(zero), .dmem_ready(dmem_ready),
    .pcsourse(pcsourse), .pcwrite(pcwrite), .pccen(pccen), .irwrite(irwrite),
    .wbsel(wbsel), .regwen(regwen), .immsel(immsel), .asel(asel), .bsel(bsel),
    .alusel(alusel), .mdrwrite(mdrwrite), .dmem_wen(dmem_wen), .retire(retire),
    .halted(halted), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       pcs;
    logic       pcw;
    logic       pcc;
    logic       irw;
    logic [1:0] wb;
    logic       rw;
    logic [2:0] imm;
    logic [1:0] as;
    logic       bs;
    logic [3:0] alu;
    logic       mdr;
    logic       dw;
    logic       ret;
    logic       hlt;
  } rec_t;

  typedef struct {
    string       name;
    logic [31:0] ins;
    logic        z;
    int          waits;
    int          exp_len;
    logic [3:0]  exp_alu2;
    logic        exp_pcw_last;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  rec_t exp_q[$];
  bit   rdy_q[$];

  function automatic rec_t sample();
    rec_t r;
    r.st = state_o;  r.pcs = pcsourse; r.pcw = pcwrite; r.pcc = pccen;
    r.irw = irwrite; r.wb = wbsel;     r.rw = regwen;    r.imm = immsel;
    r.as = asel;     r.bs = bsel;      r.alu = alusel;   r.mdr = mdrwrite;
    r.dw = dmem_wen; r.ret = retire;   r.hlt = halted;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic chk_rec(input string name, input int cyc, input rec_t a, input rec_t e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s cyc=%0d got st=%0d vec=%h want st=%0d vec=%h",
               name, cyc, a.st, a, e.st, e);
    end
  endtask

  function automatic void push(input rec_t r, input bit rdy);
    exp_q.push_back(r);
    rdy_q.push_back(rdy);
  endfunction

  // Instruction-level reference: the cycle-by-cycle control vector an
  // instruction should produce, from fetch to its last cycle.
  function automatic void build(input logic [31:0] ins, input logic z, input int waits);
    rec_t       r;
    int         w;
    logic [6:0] op;
    logic [2:0] f3;
    logic       b30, tk;
    op  = ins[6:0];
    f3  = ins[14:12];
    b30 = ins[30];
    w   = MEMWAIT ? waits : 0;
    exp_q.delete();
    rdy_q.delete();

    r = '0; r.st = FETCH; r.pcw = 1'b1; r.pcc = 1'b1; r.irw = 1'b1;
    push(r, 1'($urandom_range(0, 1)));

    r = '0; r.st = DECODE; r.as = 2'd1; r.bs = 1'b1; r.alu = 4'h0;
    r.imm = (op == 7'b1100011) ? 3'd1 : (op == 7'b1101111) ? 3'd0 : 3'd3;
    push(r, 1'($urandom_range(0, 1)));

    r = '0;
    if (op == 7'b0110011) begin
      r.st = EXEC_R; r.alu = {b30, f3};
      push(r, 1'b1);
      r.st = WB_ALU; r.wb = 2'd1; r.rw = 1'b1; r.ret = 1'b1;
      push(r, 1'b1);
    end else if (op == 7'b0010011) begin
      r.st = EXEC_I; r.bs = 1'b1; r.imm = 3'd3;
      r.alu = (f3 == 3'd5) ? {b30, f3} : {1'b0, f3};
      push(r, 1'b1);
      r.st = WB_ALU; r.wb = 2'd1; r.rw = 1'b1; r.ret = 1'b1;
      push(r, 1'b1);
    end else if (op == 7'b0000011 && f3 == 3'b010) begin
      r.st = ADDR_L; r.bs = 1'b1; r.imm = 3'd3;
      push(r, 1'b1);
      r.st = MEM_RD; r.mdr = 1'b1;
      for (int k = 0; k <= w; k++) push(r, MEMWAIT ? (k == w) : 1'b0);
      r = '0; r.st = WB_MEM; r.wb = 2'd0; r.rw = 1'b1; r.ret = 1'b1;
      push(r, 1'b1);
    end else if (op == 7'b0100011 && f3 == 3'b010) begin
      r.st = ADDR_S; r.bs = 1'b1; r.imm = 3'd2;
      push(r, 1'b1);
      r.st = MEM_WR; r.dw = 1'b1;
      for (int k = 0; k <= w; k++) begin
        r.ret = (k == w);
        push(r, MEMWAIT ? (k == w) : 1'b0);
      end
    end else if (op == 7'b1100011 && f3[2:1] == 2'b00) begin
      tk = z ^ f3[0];
      r.st = BRANCH; r.alu = 4'b1000; r.pcw = tk; r.pcs = tk; r.ret = 1'b1;
      push(r, 1'b1);
    end else if (op == 7'b1101111) begin
      r.st = JAL; r.wb = 2'd2; r.rw = 1'b1; r.pcw = 1'b1; r.pcs = 1'b1; r.ret = 1'b1;
      push(r, 1'b1);
    end else begin
      r.st = HALT; r.hlt = 1'b1;
      for (int k = 0; k < 10; k++) push(r, 1'($urandom_range(0, 1)));
    end
  endfunction

  // Entered just after a rising edge with the DUT in FETCH; leaves just
  // after the rising edge that follows the last expected cycle.
  task automatic run_seq(input string name, input logic [31:0] ins, input logic z,
                         output int len, output int nret, output logic [3:0] alu2,
                         output logic pcw_last);
    rec_t a;
    int   n;
    n = exp_q.size();
    len = 0; nret = 0; alu2 = 4'h0; pcw_last = 1'b0;
    instr = ins;
    zero  = z;
    for (int i = 0; i < n; i++) begin
      dmem_ready = rdy_q[i];
      #3;
      a = sample();
      chk_rec(name, i, a, exp_q[i]);
      if (a.ret) begin
        nret++;
        if (len == 0) len = i + 1;
      end
      if (i == 2) alu2 = a.alu;
      pcw_last = a.pcw;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk_rec("reset_outputs", 0, sample(), rec_t'('0));
    @(posedge clk);
    #1;
    chk_rec("reset_hold", 0, sample(), rec_t'('0));
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  vec_t        vt[12];
  int          len, nret;
  logic [3:0]  alu2;
  logic        pcwl;
  logic [31:0] ins;
  logic        z;
  int          cls, w;
  rec_t        zrec;

  initial begin
    rst = 1'b1; instr = 32'h0; zero = 1'b0; dmem_ready = 1'b0;
    zrec = '0;

    vt[0]  = '{"add",      32'h002081B3, 1'b0, 0, 4, 4'b0000, 1'b0};
    vt[1]  = '{"sub",      32'h402081B3, 1'b0, 0, 4, 4'b1000, 1'b0};
    vt[2]  = '{"srai",     32'h4022D293, 1'b0, 0, 4, 4'b1101, 1'b0};
    vt[3]  = '{"andi_b30", 32'hFFF0F093, 1'b0, 0, 4, 4'b0111, 1'b0};
    vt[4]  = '{"sra",      32'h4020D1B3, 1'b1, 0, 4, 4'b1101, 1'b0};
    vt[5]  = '{"lw",       32'h0080A203, 1'b0, 2, MEMWAIT ? 7 : 5, 4'b0000, 1'b0};
    vt[6]  = '{"sw",       32'h0020A223, 1'b0, 1, MEMWAIT ? 5 : 4, 4'b0000, 1'b0};
    vt[7]  = '{"beq_z1",   32'h00208863, 1'b1, 0, 3, 4'b1000, 1'b1};
    vt[8]  = '{"beq_z0",   32'h00208863, 1'b0, 0, 3, 4'b1000, 1'b0};
    vt[9]  = '{"bne_z1",   32'h00209863, 1'b1, 0, 3, 4'b1000, 1'b0};
    vt[10] = '{"bne_z0",   32'h00209863, 1'b0, 0, 3, 4'b1000, 1'b1};
    vt[11] = '{"jal",      32'h008000EF, 1'b0, 0, 3, 4'b0000, 1'b1};

    do_reset();

    // Directed table, back to back without reset in between
    for (int i = 0; i < 12; i++) begin
      build(vt[i].ins, vt[i].z, vt[i].waits);
      run_seq(vt[i].name, vt[i].ins, vt[i].z, len, nret, alu2, pcwl);
      chk({vt[i].name, "_len"}, len, vt[i].exp_len);
      chk({vt[i].name, "_nret"}, nret, 1);
      chk({vt[i].name, "_alu_c3"}, int'(alu2), int'(vt[i].exp_alu2));
      chk({vt[i].name, "_pcw_last"}, int'(pcwl), int'(vt[i].exp_pcw_last));
    end

    // Illegal opcode parks in HALT with no enables
    build(32'h0000007F, 1'b0, 0);
    run_seq("halt", 32'h0000007F, 1'b0, len, nret, alu2, pcwl);
    chk("halt_nret", nret, 0);
    chk("halt_state", int'(state_o), int'(HALT));
    do_reset();

    // Reset asserted in EXEC_R aborts the add with no register write
    build(32'h002081B3, 1'b0, 0);
    exp_q = exp_q[0:1];
    rdy_q = rdy_q[0:1];
    run_seq("rst_mid_pre", 32'h002081B3, 1'b0, len, nret, alu2, pcwl);
    chk("rst_mid_in_exec", int'(state_o), int'(EXEC_R));
    rst = 1'b1;
    #1;
    chk_rec("rst_mid_outputs", 0, sample(), zrec);
    @(posedge clk);
    #1;
    chk_rec("rst_mid_edge", 0, sample(), zrec);
    rst = 1'b0;
    build(32'h002081B3, 1'b0, 0);
    run_seq("after_rst_add", 32'h002081B3, 1'b0, len, nret, alu2, pcwl);
    chk("after_rst_len", len, 4);

    // Random instruction stream
    for (int k = 0; k < 300; k++) begin
      cls = $urandom_range(0, 15);
      ins = $urandom;
      z   = 1'($urandom_range(0, 1));
      w   = $urandom_range(0, 3);
      case (cls)
        0, 1, 2:    ins[6:0] = 7'b0110011;
        3, 4, 5:    ins[6:0] = 7'b0010011;
        6, 7: begin
          ins[6:0] = 7'b0000011;
          if ($urandom_range(0, 3) != 0) ins[14:12] = 3'b010;
        end
        8, 9: begin
          ins[6:0] = 7'b0100011;
          if ($urandom_range(0, 3) != 0) ins[14:12] = 3'b010;
        end
        10, 11, 12: begin
          ins[6:0] = 7'b1100011;
          if ($urandom_range(0, 3) != 0) ins[14:12] = {2'b00, ins[12]};
        end
        13, 14:     ins[6:0] = 7'b1101111;
        default:    ;
      endcase
      build(ins, z, w);
      run_seq("random", ins, z, len, nret, alu2, pcwl);
      if (exp_q[exp_q.size() - 1].hlt) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
